// File: rtl/xcore_id_alu_dispatch_pkg.sv
// Shared constants for the Xcore ID->EX dispatch stage: ALU control encodings,
// RV32I opcode/funct3 values and the dispatched bundle layout.
package xcore_id_alu_dispatch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SHIFT = 3'b001,
        ALU_SLT   = 3'b010,
        ALU_PASSB = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_AND   = 3'b101,
        ALU_OR    = 3'b110
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        alu_op_e          aluctrl;
        logic             a_l;
        logic             l_r;
        logic             u_s;
        logic             sub_add;
        logic [XLEN-1:0]  data_a;
        logic [XLEN-1:0]  data_b;
        logic [4:0]       rd;
        logic             illegal;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } src_t;

    // Operand a is taken from rs1 for these opcodes.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OPIMM) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
    endfunction

    // Operand b is taken from rs2 for these opcodes.
    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/xcore_id_alu_dispatch_decode.sv
// Combinational RV32I decoder: instruction word, pc and register data to the
// ALU control bundle and final operands.
module xcore_dispatch_decode
    import xcore_id_alu_dispatch_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [2:0]      aluctrl,
    output logic            a_l,
    output logic            l_r,
    output logic            u_s,
    output logic            sub_add,
    output logic [XLEN-1:0] data_a,
    output logic [XLEN-1:0] data_b,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    alu_op_e         op;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'h000};

    always_comb begin
        op      = ALU_ADD;
        a_l     = 1'b0;
        l_r     = 1'b0;
        u_s     = 1'b0;
        sub_add = 1'b0;
        data_a  = '0;
        data_b  = '0;
        rd      = instr[11:7];
        illegal = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                data_a = rs1;
                data_b = (opcode == OPC_OP) ? rs2 : imm_i;
                // Immediate shifts take the zero-extended shamt, not the full I-imm.
                if (opcode == OPC_OPIMM && (f3 == F3_SLL || f3 == F3_SR))
                    data_b = {{(XLEN-5){1'b0}}, instr[24:20]};
                case (f3)
                    F3_ADD:  sub_add = (opcode == OPC_OP) && instr[30];
                    F3_SLL:  op = ALU_SHIFT;
                    F3_SR: begin
                        op  = ALU_SHIFT;
                        l_r = 1'b1;
                        a_l = instr[30];
                    end
                    F3_SLT: begin
                        op      = ALU_SLT;
                        sub_add = 1'b1;
                    end
                    F3_SLTU: begin
                        op      = ALU_SLT;
                        sub_add = 1'b1;
                        u_s     = 1'b1;
                    end
                    F3_XOR:  op = ALU_XOR;
                    F3_OR:   op = ALU_OR;
                    F3_AND:  op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                op     = ALU_PASSB;
                data_b = imm_u;
            end
            OPC_AUIPC: begin
                data_a = pc;
                data_b = imm_u;
            end
            OPC_LOAD, OPC_JALR: begin
                data_a = rs1;
                data_b = imm_i;
            end
            OPC_STORE: begin
                data_a = rs1;
                data_b = imm_s;
                rd     = '0;
            end
            OPC_BRANCH: begin
                op      = ALU_SLT;
                sub_add = 1'b1;
                u_s     = f3[1];
                data_a  = rs1;
                data_b  = rs2;
                rd      = '0;
            end
            OPC_JAL: begin
                data_a = pc;
                data_b = XLEN'(4);
            end
            default: begin
                illegal = 1'b1;
                rd      = '0;
            end
        endcase
    end

    assign aluctrl = op;

endmodule

// File: rtl/xcore_id_alu_dispatch.sv
// ID->EX dispatch stage: decoder feeding a 2-entry skid buffer with registered in_ready.
// Optional operand forwarding is enabled by defining XCORE_DISPATCH_FWD_EN.
module xcore_id_alu_dispatch
    import xcore_id_alu_dispatch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
`ifdef XCORE_DISPATCH_FWD_EN
    input  logic             fwd_valid,
    input  logic [4:0]       fwd_rd,
    input  logic [WIDTH-1:0] fwd_data,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_aluctrl,
    output logic             out_a_l,
    output logic             out_l_r,
    output logic             out_u_s,
    output logic             out_sub_add,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [4:0]       out_rd,
    output logic             out_illegal
);

    bundle_t          dec_b;
    bundle_t          ent0_q, ent1_q;
    bundle_t          ent0_f, ent1_f;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             in_ready_q;
    logic             acc, drn;
    logic             ld0_new, ld0_ent1, ld1_new;
    logic [WIDTH-1:0] rs1_f, rs2_f;
    logic [2:0]       dec_ctrl;

`ifdef XCORE_DISPATCH_FWD_EN
    src_t src_new, src0_q, src1_q;

    function automatic logic fwd_hit(input logic v, input logic [4:0] frd, input logic [4:0] r);
        return v && (frd != '0) && (frd == r);
    endfunction

    // Buffered entries keep their source indices so stored operands can be rewritten.
    always_comb begin
        src_new = '{rs1: in_instr[19:15], rs2: in_instr[24:20],
                    use1: uses_rs1(in_instr[6:0]), use2: uses_rs2(in_instr[6:0])};
        rs1_f   = fwd_hit(fwd_valid, fwd_rd, in_instr[19:15]) ? fwd_data : in_rs1;
        rs2_f   = fwd_hit(fwd_valid, fwd_rd, in_instr[24:20]) ? fwd_data : in_rs2;
        ent0_f  = ent0_q;
        ent1_f  = ent1_q;
        if (src0_q.use1 && fwd_hit(fwd_valid, fwd_rd, src0_q.rs1)) ent0_f.data_a = fwd_data;
        if (src0_q.use2 && fwd_hit(fwd_valid, fwd_rd, src0_q.rs2)) ent0_f.data_b = fwd_data;
        if (src1_q.use1 && fwd_hit(fwd_valid, fwd_rd, src1_q.rs1)) ent1_f.data_a = fwd_data;
        if (src1_q.use2 && fwd_hit(fwd_valid, fwd_rd, src1_q.rs2)) ent1_f.data_b = fwd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src0_q <= '0;
            src1_q <= '0;
        end else if (!flush) begin
            if (ld0_new)       src0_q <= src_new;
            else if (ld0_ent1) src0_q <= src1_q;
            if (ld1_new)       src1_q <= src_new;
        end
    end
`else
    assign rs1_f  = in_rs1;
    assign rs2_f  = in_rs2;
    assign ent0_f = ent0_q;
    assign ent1_f = ent1_q;
`endif

    xcore_dispatch_decode u_decode (
        .instr   (in_instr),
        .pc      (in_pc),
        .rs1     (rs1_f),
        .rs2     (rs2_f),
        .aluctrl (dec_ctrl),
        .a_l     (dec_b.a_l),
        .l_r     (dec_b.l_r),
        .u_s     (dec_b.u_s),
        .sub_add (dec_b.sub_add),
        .data_a  (dec_b.data_a),
        .data_b  (dec_b.data_b),
        .rd      (dec_b.rd),
        .illegal (dec_b.illegal)
    );

    assign dec_b.aluctrl = alu_op_e'(dec_ctrl);

    // Entry 1 only fills while entry 0 is stalled; in_ready is its registered complement.
    always_comb begin
        acc      = in_valid & in_ready_q;
        drn      = vld_q[0] & out_ready;
        ld0_new  = 1'b0;
        ld0_ent1 = 1'b0;
        ld1_new  = 1'b0;
        vld_d    = vld_q;
        if (vld_q[1]) begin
            if (drn) begin
                ld0_ent1 = 1'b1;
                vld_d[1] = 1'b0;
            end
        end else if (vld_q[0]) begin
            if (drn && acc) begin
                ld0_new = 1'b1;
            end else if (drn) begin
                vld_d[0] = 1'b0;
            end else if (acc) begin
                ld1_new  = 1'b1;
                vld_d[1] = 1'b1;
            end
        end else if (acc) begin
            ld0_new  = 1'b1;
            vld_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            in_ready_q <= 1'b1;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else if (flush) begin
            vld_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            vld_q      <= vld_d;
            in_ready_q <= !vld_d[1];
            if (ld0_new)       ent0_q <= dec_b;
            else if (ld0_ent1) ent0_q <= ent1_f;
            else               ent0_q <= ent0_f;
            if (ld1_new)       ent1_q <= dec_b;
            else               ent1_q <= ent1_f;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = vld_q[0];
    assign out_aluctrl = ent0_q.aluctrl;
    assign out_a_l     = ent0_q.a_l;
    assign out_l_r     = ent0_q.l_r;
    assign out_u_s     = ent0_q.u_s;
    assign out_sub_add = ent0_q.sub_add;
    assign out_data_a  = ent0_q.data_a;
    assign out_data_b  = ent0_q.data_b;
    assign out_rd      = ent0_q.rd;
    assign out_illegal = ent0_q.illegal;

endmodule

// File: tb/tb_xcore_id_alu_dispatch.sv
// Self-checking bench for xcore_id_alu_dispatch: directed steps plus a randomized
// stream checked against a queue-based reference of the dispatch stage.
module tb_xcore_id_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
    logic [2:0]  out_aluctrl;
    logic        out_a_l, out_l_r, out_u_s, out_sub_add, out_illegal;
    logic [31:0] out_data_a, out_data_b;
    logic [4:0]  out_rd;
`ifdef XCORE_DISPATCH_FWD_EN
    logic        fwd_valid = 1'b0;
    logic [4:0]  fwd_rd = '0;
    logic [31:0] fwd_data = '0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xcore_id_alu_dispatch #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
`ifdef XCORE_DISPATCH_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluctrl(out_aluctrl), .out_a_l(out_a_l), .out_l_r(out_l_r),
        .out_u_s(out_u_s), .out_sub_add(out_sub_add),
        .out_data_a(out_data_a), .out_data_b(out_data_b),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [2:0]  ctrl;
        logic        a_l, l_r, u_s, sub;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    // Reference decode written from the instruction-set table.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] immi, imms, immu;
        op   = ins[6:0];
        f3   = ins[14:12];
        immi = 32'($signed(ins[31:20]));
        imms = 32'($signed({ins[31:25], ins[11:7]}));
        immu = {ins[31:12], 12'h000};
        e = '{ctrl: 3'd0, a_l: 1'b0, l_r: 1'b0, u_s: 1'b0, sub: 1'b0,
              a: 32'd0, b: 32'd0, rd: ins[11:7], ill: 1'b0};
        case (op)
            7'h33, 7'h13: begin
                e.a = r1;
                e.b = (op == 7'h33) ? r2 : immi;
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) e.b = 32'(ins[24:20]);
                case (f3)
                    3'd0: e.sub = (op == 7'h33) && ins[30];
                    3'd1: e.ctrl = 3'd1;
                    3'd5: begin e.ctrl = 3'd1; e.l_r = 1'b1; e.a_l = ins[30]; end
                    3'd2: begin e.ctrl = 3'd2; e.sub = 1'b1; end
                    3'd3: begin e.ctrl = 3'd2; e.sub = 1'b1; e.u_s = 1'b1; end
                    3'd4: e.ctrl = 3'd4;
                    3'd6: e.ctrl = 3'd6;
                    default: e.ctrl = 3'd5;
                endcase
            end
            7'h37: begin e.ctrl = 3'd3; e.b = immu; end
            7'h17: begin e.a = pc; e.b = immu; end
            7'h03, 7'h67: begin e.a = r1; e.b = immi; end
            7'h23: begin e.a = r1; e.b = imms; e.rd = 5'd0; end
            7'h63: begin
                e.ctrl = 3'd2; e.sub = 1'b1; e.u_s = ins[13];
                e.a = r1; e.b = r2; e.rd = 5'd0;
            end
            7'h6f: begin e.a = pc; e.b = 32'd4; end
            default: begin e.ill = 1'b1; e.rd = 5'd0; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one clock, updating the reference queue with the handshakes of that edge.
    task automatic tick();
        bit acc, drn;
        @(posedge clk);
        acc = in_valid && (q.size() < 2) && !flush;
        drn = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(in_instr, in_pc, in_rs1, in_rs2));
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, out_valid, q.size() > 0);
        chk({tag, ".in_ready"}, in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk({tag, ".ctrl"}, out_aluctrl, q[0].ctrl);
            chk({tag, ".flags"}, {out_a_l, out_l_r, out_u_s, out_sub_add},
                {q[0].a_l, q[0].l_r, q[0].u_s, q[0].sub});
            chk({tag, ".data_a"}, out_data_a, q[0].a);
            chk({tag, ".data_b"}, out_data_b, q[0].b);
            chk({tag, ".rd"}, out_rd, q[0].rd);
            chk({tag, ".illegal"}, out_illegal, q[0].ill);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".valid"}, out_valid, 0);
        chk({tag, ".in_ready"}, in_ready, 1);
        chk({tag, ".ctrl"}, out_aluctrl, 0);
        chk({tag, ".flags"}, {out_a_l, out_l_r, out_u_s, out_sub_add, out_illegal}, 0);
        chk({tag, ".data_a"}, out_data_a, 0);
        chk({tag, ".data_b"}, out_data_b, 0);
        chk({tag, ".rd"}, out_rd, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h67, 7'h63, 7'h6f, 7'h7f, 7'h0f};
        r = $urandom();
        return {r[31:7], ops[$urandom_range(0, 10)]};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // ADDI x5,x1,-1
        in_valid = 1'b1; out_ready = 1'b1; in_rs1 = 32'd10; in_pc = 32'h100;
        in_instr = enc_i(12'hFFF, 5'd1, 3'd0, 5'd5, 7'h13);
        tick();
        chk("addi.valid", out_valid, 1);
        chk("addi.ctrl", out_aluctrl, 3'b000);
        chk("addi.data_a", out_data_a, 32'd10);
        chk("addi.data_b", out_data_b, 32'hFFFF_FFFF);
        chk("addi.rd", out_rd, 5'd5);

        // SRAI x3,x2,4 then SLTU x6,x7,x8
        in_rs1 = 32'h8000_0000;
        in_instr = enc_i({7'h20, 5'd4}, 5'd2, 3'd5, 5'd3, 7'h13);
        tick();
        chk("srai.ctrl", out_aluctrl, 3'b001);
        chk("srai.lr_al", {out_l_r, out_a_l}, 2'b11);
        chk("srai.data_b", out_data_b, 32'd4);
        in_rs2 = 32'd77;
        in_instr = enc_r(7'h00, 5'd8, 5'd7, 3'd3, 5'd6, 7'h33);
        tick();
        chk("sltu.ctrl", out_aluctrl, 3'b010);
        chk("sltu.us_sub", {out_u_s, out_sub_add}, 2'b11);
        check_model("sltu");
        in_valid = 1'b0;
        tick();

        // Stall four cycles with continuous input
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = enc_i(12'(i + 1), 5'd1, 3'd0, 5'(i + 1), 7'h13);
            tick();
            chk("stall.in_ready", in_ready, (i == 0) ? 1 : 0);
            check_model("stall");
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("release.first_b", out_data_b, 32'd1);
        tick();
        chk("release.second_b", out_data_b, 32'd2);
        chk("release.in_ready", in_ready, 1);
        tick();
        chk("release.empty", out_valid, 0);

        // Flush while full with an input pending
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        chk("flush.valid", out_valid, 0);
        chk("flush.in_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush.gone", out_valid, 0);
        end

        // Illegal opcode
        in_valid = 1'b1; in_rs1 = 32'h1234; in_rs2 = 32'h5678;
        in_instr = {25'h1ABCDEF, 7'h7F};
        tick();
        chk("illegal.flag", out_illegal, 1);
        chk("illegal.rd", out_rd, 0);
        chk("illegal.ops", out_data_a | out_data_b, 0);
        in_valid = 1'b0;
        tick();

        // Randomized stream with a mid-stream asynchronous reset
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom();
            in_rs1    = $urandom();
            in_rs2    = $urandom();
            if (c == 200) begin
                #2 rst = 1'b1;
                #1 check_reset("async_reset");
                q.delete();
                @(negedge clk);
                rst = 1'b0;
                check_reset("after_reset");
            end
            tick();
            check_model("rand");
        end

`ifdef XCORE_DISPATCH_FWD_EN
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        // ADD x2,x1,x1 with x1 forwarded at acceptance
        out_ready = 1'b0; in_valid = 1'b1; in_rs1 = 32'h1234; in_rs2 = 32'h1234;
        fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'h55;
        in_instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2, 7'h33);
        tick();
        chk("fwd.data_a", out_data_a, 32'h55);
        chk("fwd.data_b", out_data_b, 32'h55);
        // A later match rewrites the buffered operands
        in_valid = 1'b0; fwd_data = 32'hAA;
        tick();
        chk("fwd_buf.data_a", out_data_a, 32'hAA);
        chk("fwd_buf.data_b", out_data_b, 32'hAA);
        // x0 is never forwarded
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b1; in_rs1 = 32'd7; in_rs2 = 32'd7;
        fwd_rd = 5'd0; fwd_data = 32'h55;
        in_instr = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd2, 7'h33);
        tick();
        chk("fwd_x0.data_a", out_data_a, 32'd7);
        fwd_valid = 1'b0; in_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
